// File: rtl/capi_put_align_shift_n.sv
// rtl/capi_put_align_shift_n.sv - put-data byte aligner with carry and trailing flush beat
//
// Purpose:
//   Shifts each put-data stream so that its first byte lands at a per-stream
//   destination byte offset. Bytes pushed past the end of a beat are carried
//   into the next beat. If the shifted stream runs past its last beat, one
//   extra flush beat is emitted. Byte enables, the final-beat byte count and
//   first/last markers are produced for the command generator and write array.
//   Byte 0 of every data bus sits in the most significant byte lane, and bit
//   BYTES-1 of o_be is the enable for byte 0.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   i_v/i_r           input beat handshake
//   i_d               input data, BYTES bytes
//   i_c               valid bytes in the last beat (0 = BYTES), used with i_e
//   i_e               last input beat of the stream
//   i_a_v/i_a_r       per-stream offset handshake
//   i_a_d             destination byte offset of the first byte
//   o_v/o_r           output beat handshake
//   o_d               aligned data
//   o_be              byte enables
//   o_c               valid bytes in the final beat (0 = BYTES), else 0
//   o_e               final output beat of the stream
//   o_s               first output beat of the stream

module capi_put_align_shift_n #(
  parameter int BYTES = 16,
  parameter int CW    = $clog2(BYTES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_v,
  output logic                 i_r,
  input  logic [8*BYTES-1:0]   i_d,
  input  logic [CW-1:0]        i_c,
  input  logic                 i_e,
  input  logic                 i_a_v,
  output logic                 i_a_r,
  input  logic [CW-1:0]        i_a_d,
  input  logic                 o_r,
  output logic                 o_v,
  output logic [8*BYTES-1:0]   o_d,
  output logic [BYTES-1:0]     o_be,
  output logic [CW-1:0]        o_c,
  output logic                 o_e,
  output logic                 o_s
);

  localparam int DW = 8 * BYTES;
  localparam logic [CW:0] FULL = (CW+1)'(BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        off_q, off_d;
  logic                 first_q, first_d;
  logic [DW-1:0]        carry_q, carry_d;
  logic [CW-1:0]        fcnt_q, fcnt_d;
  logic                 o_v_q, o_v_d;
  logic [DW-1:0]        o_d_q, o_d_d;
  logic [BYTES-1:0]     o_be_q, o_be_d;
  logic [CW-1:0]        o_c_q, o_c_d;
  logic                 o_e_q, o_e_d;
  logic                 o_s_q, o_s_d;

  logic [CW:0]          ce;
  logic [CW:0]          tot;
  logic [CW:0]          rem;
  logic                 ovf;
  logic                 out_free;
  logic [DW-1:0]        shifted;
  int                   be_lo;

  // Enables for byte positions lo .. hi-1 (byte 0 is the MSB of the mask).
  function automatic logic [BYTES-1:0] be_range(input int lo, input int hi);
    logic [BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (i >= lo && i < hi) m[BYTES-1-i] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    first_d  = first_q;
    carry_d  = carry_q;
    fcnt_d   = fcnt_q;
    o_d_d    = o_d_q;
    o_be_d   = o_be_q;
    o_c_d    = o_c_q;
    o_e_d    = o_e_q;
    o_s_d    = o_s_q;
    i_r      = 1'b0;
    i_a_r    = 1'b0;

    out_free = ~o_v_q | o_r;
    o_v_d    = o_v_q & ~o_r;

    ce       = (i_c == '0) ? FULL : {1'b0, i_c};
    tot      = {1'b0, off_q} + ce;
    rem      = FULL - {1'b0, off_q};
    ovf      = tot > FULL;
    be_lo    = first_q ? int'(off_q) : 0;
    // Carry bytes already sit in lanes 0..off-1 with zeros below them.
    shifted  = carry_q | (i_d >> {off_q, 3'b000});

    case (state_q)
      ST_IDLE: begin
        i_a_r = 1'b1;
        if (i_a_v) begin
          off_d   = i_a_d;
          first_d = 1'b1;
          carry_d = '0;
          state_d = ST_STREAM;
        end
      end

      ST_STREAM: begin
        i_r = out_free;
        if (i_v && out_free) begin
          o_v_d   = 1'b1;
          o_d_d   = shifted;
          o_s_d   = first_q;
          first_d = 1'b0;
          // off==0 would shift by the full bus width; keep the carry empty.
          carry_d = (off_q == '0) ? '0 : (i_d << {rem, 3'b000});
          o_e_d   = 1'b0;
          o_c_d   = '0;
          o_be_d  = be_range(be_lo, BYTES);
          if (i_e) begin
            if (!ovf) begin
              o_e_d   = 1'b1;
              o_c_d   = tot[CW-1:0];
              o_be_d  = be_range(be_lo, int'(tot));
              state_d = ST_IDLE;
            end else begin
              // tot lies in (BYTES, 2*BYTES), so dropping its top bit
              // yields tot - BYTES: the byte count left for the flush beat.
              fcnt_d  = tot[CW-1:0];
              state_d = ST_FLUSH;
            end
          end
        end
      end

      ST_FLUSH: begin
        if (out_free) begin
          o_v_d   = 1'b1;
          o_d_d   = carry_q;
          o_be_d  = be_range(0, int'(fcnt_q));
          o_c_d   = fcnt_q;
          o_e_d   = 1'b1;
          o_s_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      off_q   <= '0;
      first_q <= 1'b0;
      carry_q <= '0;
      fcnt_q  <= '0;
      o_v_q   <= 1'b0;
      o_d_q   <= '0;
      o_be_q  <= '0;
      o_c_q   <= '0;
      o_e_q   <= 1'b0;
      o_s_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      first_q <= first_d;
      carry_q <= carry_d;
      fcnt_q  <= fcnt_d;
      o_v_q   <= o_v_d;
      o_d_q   <= o_d_d;
      o_be_q  <= o_be_d;
      o_c_q   <= o_c_d;
      o_e_q   <= o_e_d;
      o_s_q   <= o_s_d;
    end
  end

  assign o_v  = o_v_q;
  assign o_d  = o_d_q;
  assign o_be = o_be_q;
  assign o_c  = o_c_q;
  assign o_e  = o_e_q;
  assign o_s  = o_s_q;

endmodule

// File: doc/capi_put_align_shift_n.md
Name: capi_put_align_shift_n

Overview:
- Parametrised next-generation put-data byte aligner for the CAPI put path.
- Takes a stream of BYTES-wide data beats plus a per-stream destination byte offset, and shifts each stream so its first byte lands at that offset.
- Carries the spill-over bytes between beats and inserts a trailing flush beat when the shifted stream overflows its last beat.
- Drives byte enables and a final-beat count downstream, toward the command generator and the write array.

Parameters:
BYTES, 16, data beat width in bytes; power of two, 4..64.
CW, $clog2(BYTES), width of count and offset fields.

Ports:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-low reset.
i_v  in  1  input data beat valid.
i_r  out  1  input data ready.
i_d  in  8*BYTES  input data; byte 0 at MSB ([0:7]).
i_c  in  CW  valid bytes in the last beat; 0 means BYTES; ignored unless i_e.
i_e  in  1  last beat of stream.
i_a_v  in  1  offset valid, one per stream.
i_a_r  out  1  offset ready.
i_a_d  in  CW  destination byte offset of the first byte.
o_r  in  1  output ready.
o_v  out  1  output beat valid.
o_d  out  8*BYTES  aligned data.
o_be  out  BYTES  byte enables.
o_c  out  CW  valid bytes in the final beat; 0 means BYTES.
o_e  out  1  final output beat of stream.
o_s  out  1  first output beat of stream.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; carry register cleared; o_v=0.
  - o_d, o_be, o_c, o_e, o_s all 0; i_r=0; i_a_r=1.
  - Reset asserted mid-stream discards the carry and any pending flush; there is no partial output afterward.
- State machine IDLE/STREAM/FLUSH:
  - IDLE: i_a_r=1, i_r=0.
    - i_a_v & i_a_r latches off=i_a_d, sets first=1 and goes to STREAM.
  - STREAM: i_a_r=0; i_r = ~o_v | o_r (single output register, full-throughput skid-free).
    - Input beat accepted: build output from carry bytes [0:off-1] followed by i_d bytes [0:BYTES-off-1].
    - New carry = i_d bytes [BYTES-off:BYTES-1].
  - FLUSH: i_r=0, i_a_r=0. Emits the carry as one beat when the output register frees, then goes to IDLE.
- Latency: one clock from input accept to o_v. The offset handshake adds one clock before the first data beat can be accepted.
- Byte enables:
  - First output beat: o_be bits [off:BYTES-1] set, unless the stream also ends on that beat (see below).
  - Middle beats: all ones.
  - Final beat: bits [0:n-1] set, where n is the final-beat byte count.
  - A single-beat stream without overflow has bits [off:off+ce-1] set.
- Final-beat arithmetic. Let ce = (i_c==0) ? BYTES : i_c, computed at CW+1 bits, and tot = off + ce.
  - tot <= BYTES: the accepted last beat is final. o_e=1, o_c=tot[CW-1:0]; tot==BYTES gives o_c=0.
  - tot > BYTES: that beat goes out with o_e=0 and full enables from off. Then FLUSH emits o_e=1, o_c=tot-BYTES, o_be=[0:tot-BYTES-1].
  - o_c is 0 on non-final beats.
- o_s=1 only on the first output beat of a stream; o_s and o_e may both be 1.
- off==0 is pure pass-through: carry is unused and FLUSH is never entered.
- Back-to-back streams:
  - The next offset is accepted only in IDLE. There is no overlap with the FLUSH beat.
  - The end of a stream with tot<=BYTES returns to IDLE in the same cycle the last beat is accepted.
- Stalls: with o_v & ~o_r, o_d/o_be/o_c/o_e/o_s hold stable and no input is accepted.
- i_v without a prior offset is never consumed.

Test Plan:
- BYTES=16, off=0, 3-beat stream, i_c=0 -> 3 beats identical to the input; o_be=16'hFFFF; o_s on beat0; o_e on beat2 with o_c=0; no flush.
- off=4, 2 beats (bytes 0x00..0x1F), i_c=0 -> 3 output beats.
  - beat0: bytes 0..11 at positions 4..15, o_be=16'h0FFF.
  - beat1: bytes 12..27.
  - beat2 (flush): bytes 28..31 at 0..3, o_be=16'hF000, o_c=4, o_e=1.
- off=4, single beat, i_c=12 -> one beat, o_s=o_e=1, o_c=0, o_be=16'h0FFF; FSM back to IDLE, i_a_r=1 next cycle.
- off=15, single beat, i_c=2 -> beat0 with byte0 at position 15, o_e=0; flush beat with byte1 at position 0, o_c=1, o_e=1.
- Random o_r deassertion during a 4-beat off=7 stream -> outputs held stable while stalled; byte order equals the golden shifted model; no beat lost or duplicated.
- Assert reset during FLUSH after beat1 of the off=4 case -> o_v=0 next cycle, i_a_r=1, no flush beat emitted; next stream with off=0 passes through correctly.
